// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO and launch controller feeding a UART transmitter.
// The host burst-writes bytes with a valid/ready handshake. The block hands them
// to the transmitter one at a time on din/wr_en, pacing itself on tx_busy.
//
// Ports:
//   txclk    in   1      transmit-domain clock, rising edge
//   rst      in   1      synchronous active-high reset
//   wdata    in   8      host byte to enqueue
//   wvalid   in   1      host write request
//   wready   out  1      combinational !full; a push happens when wvalid && wready
//   din      out  8      byte to the transmitter, stable while wr_en=1
//   wr_en    out  1      registered launch request to the transmitter
//   tx_busy  in   1      transmitter frame in progress
//   level    out  AW+1   bytes buffered, not counting the byte in flight
//   overflow out  1      sticky flag: a write arrived while full (cleared by rst)
//   idle     out  1      combinational: empty, FSM in IDLE and !tx_busy
//   cts_n    in   1      only with UART_TX_FIFO_CTS_EN: active-low clear-to-send
//
// Build option: define UART_TX_FIFO_CTS_EN to add cts_n and gate launches on it.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          txclk,
  input  logic          rst,
`ifdef UART_TX_FIFO_CTS_EN
  input  logic          cts_n,
`endif
  input  logic [7:0]    wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic [7:0]    din,
  output logic          wr_en,
  input  logic          tx_busy,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          idle
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        go;

  // The pointers carry an extra wrap bit so that full and empty can be told apart.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wready = !full;
  assign push   = wvalid && !full;
  assign idle   = empty && (state == IDLE) && !tx_busy;

`ifdef UART_TX_FIFO_CTS_EN
  // Two-flop synchroniser. It resets to "not clear" so nothing launches until
  // cts_n has actually been seen low.
  logic [1:0] cts_sync;

  always_ff @(posedge txclk) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign go = !cts_sync[1];
`else
  assign go = 1'b1;
`endif

  // Next-state logic. A byte is popped only on the IDLE->LAUNCH transition.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy && go) begin
          state_nx = LAUNCH;
          pop      = 1'b1;
        end
      end
      LAUNCH: begin
        if (tx_busy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register. wr_en is registered from the next state so it tracks LAUNCH exactly.
  always_ff @(posedge txclk) begin
    if (rst) begin
      state <= IDLE;
      wr_en <= 1'b0;
    end else begin
      state <= state_nx;
      wr_en <= (state_nx == LAUNCH);
    end
  end

  // Storage array. It has no reset because only the pointers define its contents.
  always_ff @(posedge txclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointers, level counter, launch data and the sticky overflow flag.
  always_ff @(posedge txclk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      din      <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + LW'(1);
        din    <= mem[rd_ptr[AW-1:0]];
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (wvalid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Written bytes go into a scoreboard queue.
// A monitor pops and compares the scoreboard at the start of every wr_en episode.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       txclk = 1'b0;
  logic       rst;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic [7:0] din;
  logic       wr_en;
  logic       tx_busy;
  logic [4:0] level;
  logic       overflow;
  logic       idle;
`ifdef UART_TX_FIFO_CTS_EN
  logic       cts_n;
`endif

  int         errors   = 0;
  int         checks   = 0;
  int         episodes = 0;
  logic [7:0] sb[$];
  logic       prev_wr  = 1'b0;
  logic [7:0] prev_din = 8'h00;
  logic [7:0] mon_exp;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .txclk    (txclk),
    .rst      (rst),
`ifdef UART_TX_FIFO_CTS_EN
    .cts_n    (cts_n),
`endif
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .din      (din),
    .wr_en    (wr_en),
    .tx_busy  (tx_busy),
    .level    (level),
    .overflow (overflow),
    .idle     (idle)
  );

  always #5 txclk = ~txclk;

  // Launch monitor: every wr_en episode must consume exactly the next byte in order.
  always @(negedge txclk) begin
    if (wr_en === 1'b1 && prev_wr !== 1'b1) begin
      episodes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: din=%h launched, no byte expected", din);
      end else begin
        mon_exp = sb.pop_front();
        if (din !== mon_exp) begin
          errors++;
          $display("FAIL launch_order: din=%h, expected %h", din, mon_exp);
        end
      end
    end else if (wr_en === 1'b1) begin
      checks++;
      if (din !== prev_din) begin
        errors++;
        $display("FAIL din_stable: din=%h changed during wr_en, was %h", din, prev_din);
      end
    end
    prev_wr  = wr_en;
    prev_din = din;
  end

  task automatic step();
    @(posedge txclk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wdata  = b;
    wvalid = 1'b1;
    sb.push_back(b);
    step();
    wvalid = 1'b0;
  endtask

  // Transmitter model: tx_busy rises 3 cycles after wr_en and stays high for 10 cycles.
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (wr_en !== 1'b1 && t < 300) begin
        step();
        t++;
      end
      checks++;
      if (wr_en !== 1'b1) begin
        errors++;
        $display("FAIL serve_timeout: wr_en=%b after 300 cycles, byte %0d of %0d, expected 1", wr_en, i, n);
        return;
      end
      repeat (3) step();
      tx_busy = 1'b1;
      repeat (10) step();
      tx_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wvalid = 1'b0; wdata = 8'h00; tx_busy = 1'b0;
`ifdef UART_TX_FIFO_CTS_EN
    cts_n = 1'b0;
`endif
    step(); step();
    checks++; if (level !== 5'd0)   begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (din !== 8'h00)    begin errors++; $display("FAIL reset_din: got %h want 00", din); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (wready !== 1'b1)  begin errors++; $display("FAIL reset_wready: got %b want 1", wready); end
    rst = 1'b0;
    step();
    checks++; if (idle !== 1'b1)    begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    tx_busy = 1'b0;
    push_byte(8'hA5);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level_push: got %0d want 1", level); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_early: got %b want 0", wr_en); end
    step();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b want 1", wr_en); end
    checks++; if (din !== 8'hA5)  begin errors++; $display("FAIL single_din: got %h want a5", din); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", level); end
    repeat (3) step();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_hold: got %b want 1", wr_en); end
    tx_busy = 1'b1;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", wr_en); end
    checks++; if (idle !== 1'b0)  begin errors++; $display("FAIL single_busy_idle: got %b want 0", idle); end
    tx_busy = 1'b0;
    step();
    checks++; if (idle !== 1'b1)  begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_fill();
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    checks++; if (wready !== 1'b0)   begin errors++; $display("FAIL fill_wready: got %b want 0", wready); end
    checks++; if (level !== 5'd16)   begin errors++; $display("FAIL fill_level: got %0d want 16", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
    wdata = 8'hFF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b want 1", overflow); end
    checks++; if (level !== 5'd16)   begin errors++; $display("FAIL fill_level_after_ovf: got %0d want 16", level); end
    tx_busy = 1'b0;
    serve(16);
    step(); step();
    checks++; if (level !== 5'd0)    begin errors++; $display("FAIL fill_drain_level: got %0d want 0", level); end
    checks++; if (sb.size() != 0)    begin errors++; $display("FAIL fill_drain_sb: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int ep0 = episodes;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          int t = 0;
          repeat ($urandom_range(0, 3)) step();
          while (wready !== 1'b1 && t < 500) begin
            step();
            t++;
          end
          checks++;
          if (wready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wready_timeout: wready=%b, expected 1", wready);
          end else begin
            push_byte(8'($urandom));
          end
        end
      end
      begin
        serve(32);
      end
    join
    step(); step();
    checks++; if (episodes - ep0 != 32) begin errors++; $display("FAIL b2b_episodes: got %0d want 32", episodes - ep0); end
    checks++; if (sb.size() != 0)       begin errors++; $display("FAIL b2b_sb: got %0d left want 0", sb.size()); end
    checks++; if (level !== 5'd0)       begin errors++; $display("FAIL b2b_level: got %0d want 0", level); end
  endtask

  task automatic test_push_pop();
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL pp_level5: got %0d want 5", level); end
    // The push and the pop happen on the same edge.
    tx_busy = 1'b0;
    push_byte(8'h15);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL pp_same_cycle: got %0d want 5", level); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL pp_launch: got %b want 1", wr_en); end
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 11; i++) push_byte(8'(8'h20 + i));
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL pp_full_level: got %0d want 16", level); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL pp_full_wready: got %b want 0", wready); end
    // At full, a push that coincides with a pop is refused.
    wdata = 8'hEE; wvalid = 1'b1; tx_busy = 1'b0;
    step(); step();
    wvalid = 1'b0;
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL pp_full_pop: got %0d want 15", level); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL pp_wready_after_pop: got %b want 1", wready); end
    serve(16);
    step(); step();
    checks++; if (sb.size() != 0)  begin errors++; $display("FAIL pp_sb: got %0d left want 0", sb.size()); end
    checks++; if (level !== 5'd0)  begin errors++; $display("FAIL pp_level0: got %0d want 0", level); end
  endtask

  task automatic test_rst_mid();
    tx_busy = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
    tx_busy = 1'b1;
    step();
    checks++; if (level !== 5'd4) begin errors++; $display("FAIL rm_level4: got %0d want 4", level); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rm_wait_done: got %b want 0", wr_en); end
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    checks++; if (level !== 5'd0)    begin errors++; $display("FAIL rm_level: got %0d want 0", level); end
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL rm_wr_en: got %b want 0", wr_en); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow: got %b want 0", overflow); end
    checks++; if (idle !== 1'b0)     begin errors++; $display("FAIL rm_idle_busy: got %b want 0", idle); end
    push_byte(8'h3C);
    repeat (4) step();
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL rm_no_launch: got %b want 0", wr_en); end
    checks++; if (level !== 5'd1)    begin errors++; $display("FAIL rm_held_level: got %0d want 1", level); end
    tx_busy = 1'b0;
    serve(1);
    step(); step();
    checks++; if (sb.size() != 0)    begin errors++; $display("FAIL rm_sb: got %0d left want 0", sb.size()); end
  endtask

`ifdef UART_TX_FIFO_CTS_EN
  task automatic test_cts();
    cts_n = 1'b1; tx_busy = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) push_byte(8'(8'h50 + i));
    repeat (4) step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL cts_blocked: got %b want 0", wr_en); end
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL cts_level3: got %0d want 3", level); end
    // Two synchroniser edges, then the pop edge that enters LAUNCH.
    cts_n = 1'b0;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL cts_sync1: got %b want 0", wr_en); end
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL cts_sync2: got %b want 0", wr_en); end
    step();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL cts_launch: got %b want 1", wr_en); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL cts_level2: got %0d want 2", level); end
    repeat (2) step();
    tx_busy = 1'b1;
    cts_n = 1'b1;
    repeat (10) step();
    tx_busy = 1'b0;
    repeat (6) step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL cts_held: got %b want 0", wr_en); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL cts_held_level: got %0d want 2", level); end
    cts_n = 1'b0;
    serve(2);
    step(); step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL cts_sb: got %0d left want 0", sb.size()); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_push_pop();
    test_rst_mid();
`ifdef UART_TX_FIFO_CTS_EN
    test_cts();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
